// File: rtl/pll_clk_mgr.sv
// pll_clk_mgr: qualifies the PLL lock, releases a synchronous downstream
// reset once the clock is stable, produces NCH programmable clock-enable
// strobes and counts lock-loss events.
// Inputs are plain levels: locked_raw is asynchronous to clock_in, and div
// is a static configuration bus sampled every cycle. Outputs are levels,
// except ce, whose bits are one-cycle strobes. No valid/ready handshake is
// involved.
module pll_clk_mgr #(
   parameter int NCH         = 4,
   parameter int DIV_W       = 8,
   parameter int LOCK_WAIT   = 1024,
   parameter int GLITCH_FILT = 4
) (
   input  logic                 clock_in,
   input  logic                 resetb,
   input  logic                 locked_raw,
   input  logic [NCH*DIV_W-1:0] div,
   output logic [NCH-1:0]       ce,
   output logic                 rst_out_n,
   output logic                 ready,
   output logic [7:0]           lost_cnt,
   output logic [1:0]           state
);

   localparam int SET_W = $clog2(LOCK_WAIT);
   localparam int LOW_W = (GLITCH_FILT > 1) ? $clog2(GLITCH_FILT) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_WAIT - 1);
   localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(GLITCH_FILT - 1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_SETTLE    = 2'd1,
      ST_RUN       = 2'd2,
      ST_FAULT     = 2'd3
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   logic             w_lock_s;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [SET_W-1:0] r_settle_cnt;
   logic [SET_W-1:0] w_settle_nxt;
   logic [LOW_W-1:0] r_low_cnt;
   logic [LOW_W-1:0] w_low_nxt;
   logic [7:0]       r_lost_cnt;
   logic             r_ready;
   logic             r_rst_n;

   assign w_lock_s  = r_sync2;
   assign state     = r_state;
   assign ready     = r_ready;
   assign rst_out_n = r_rst_n;
   assign lost_cnt  = r_lost_cnt;

   // Two-flop synchroniser bringing the PLL lock into the clock_in domain.
   always_ff @(posedge clock_in or negedge resetb) begin
      if (!resetb) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= locked_raw;
         r_sync2 <= r_sync1;
      end
   end

   // State register plus qualification counters, lost-lock counter and the
   // registered ready/reset outputs (state==RUN delayed by one cycle).
   always_ff @(posedge clock_in or negedge resetb) begin
      if (!resetb) begin
         r_state      <= ST_WAIT_LOCK;
         r_settle_cnt <= '0;
         r_low_cnt    <= '0;
         r_lost_cnt   <= 8'd0;
         r_ready      <= 1'b0;
         r_rst_n      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_low_cnt    <= w_low_nxt;
         r_ready      <= (r_state == ST_RUN);
         r_rst_n      <= (r_state == ST_RUN);
         if ((r_state == ST_FAULT) && (r_lost_cnt != 8'hFF)) begin
            r_lost_cnt <= r_lost_cnt + 8'd1;
         end
      end
   end

   // Next-state logic: settle timing in SETTLE, low-run glitch filter in RUN.
   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = '0;
      w_low_nxt    = '0;
      case (r_state)
         ST_WAIT_LOCK: begin
            if (w_lock_s) w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!w_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (r_settle_cnt == SET_LAST) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_settle_nxt = r_settle_cnt + SET_W'(1);
            end
         end
         ST_RUN: begin
            if (!w_lock_s) begin
               if (r_low_cnt == LOW_LAST) begin
                  w_state_nxt = ST_FAULT;
               end else begin
                  w_low_nxt = r_low_cnt + LOW_W'(1);
               end
            end
         end
         ST_FAULT: begin
            w_state_nxt = ST_WAIT_LOCK;
         end
         default: begin
            w_state_nxt = ST_WAIT_LOCK;
         end
      endcase
   end

   // Per-channel dividers; all counters start together on RUN entry so equal
   // divisors stay phase-aligned. A divisor change applies immediately and
   // the ">=" compare wraps a counter already past the new terminal value.
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [DIV_W-1:0] w_div;
      logic [DIV_W-1:0] w_last;
      logic             w_wrap;
      logic [DIV_W-1:0] r_cnt;

      assign w_div  = div[g*DIV_W +: DIV_W];
      assign w_last = (w_div == '0) ? '0 : (w_div - DIV_W'(1));
      assign w_wrap = (r_cnt >= w_last);
      assign ce[g]  = (r_state == ST_RUN) && w_wrap;

      // Counter held at zero outside RUN, wraps on the strobe cycle.
      always_ff @(posedge clock_in or negedge resetb) begin
         if (!resetb) begin
            r_cnt <= '0;
         end else if (r_state != ST_RUN) begin
            r_cnt <= '0;
         end else if (w_wrap) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pll_clk_mgr.sv
// Bench for pll_clk_mgr: behavioural model of lock qualification and the
// clock-enable dividers, checked against the DUT on every clock.
module tb_pll_clk_mgr;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int LW  = 16;
   localparam int GF  = 4;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              resetb;
   logic              locked_raw;
   logic [NCH*DW-1:0] div;
   logic [NCH-1:0]    ce;
   logic              rst_out_n;
   logic              ready;
   logic [7:0]        lost_cnt;
   logic [1:0]        state;

   always #5 clk = ~clk;

   pll_clk_mgr #(.NCH(NCH), .DIV_W(DW), .LOCK_WAIT(LW), .GLITCH_FILT(GF)) dut (
      .clock_in  (clk),
      .resetb    (resetb),
      .locked_raw(locked_raw),
      .div       (div),
      .ce        (ce),
      .rst_out_n (rst_out_n),
      .ready     (ready),
      .lost_cnt  (lost_cnt),
      .state     (state)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_state: 0 waiting, 1 settling, 2 running, 3 fault.
   // m_settle counts qualified cycles in SETTLE, m_low the current low run.
   int m_state, m_settle, m_low, m_lost;
   bit m_s1, m_s2, m_ready;
   int m_cnt[NCH];

   function automatic int div_eff(input int i);
      int v;
      v = int'(div[i*DW +: DW]);
      return (v == 0) ? 1 : v;
   endfunction

   always @(posedge clk or negedge resetb) begin : model
      bit ls;
      if (!resetb) begin
         m_state = 0; m_settle = 0; m_low = 0; m_lost = 0;
         m_s1 = 0; m_s2 = 0; m_ready = 0;
         for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end else begin
         ls = m_s2;
         m_s2 = m_s1;
         m_s1 = locked_raw;
         m_ready = (m_state == 2);
         for (int i = 0; i < NCH; i++) begin
            if (m_state != 2) m_cnt[i] = 0;
            else if (m_cnt[i] >= div_eff(i) - 1) m_cnt[i] = 0;
            else m_cnt[i] = m_cnt[i] + 1;
         end
         case (m_state)
            0: if (ls) begin m_state = 1; m_settle = 0; end
            1: begin
               if (!ls) m_state = 0;
               else begin
                  m_settle = m_settle + 1;
                  if (m_settle == LW) begin m_state = 2; m_low = 0; end
               end
            end
            2: begin
               if (ls) m_low = 0;
               else begin
                  m_low = m_low + 1;
                  if (m_low == GF) m_state = 3;
               end
            end
            default: begin
               m_lost = (m_lost < 255) ? m_lost + 1 : 255;
               m_state = 0;
            end
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [NCH-1:0] e;
      if (resetb && chk_on) begin
         for (int i = 0; i < NCH; i++)
            e[i] = (m_state == 2) && (m_cnt[i] >= div_eff(i) - 1);
         chk("ce", ce, e);
         chk("state", state, m_state);
         chk("ready", ready, m_ready);
         chk("rst_out_n", rst_out_n, m_ready);
         chk("lost_cnt", lost_cnt, m_lost);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input int max, input string name);
      for (int k = 0; k < max && state !== s; k++) step(1);
      chk(name, state, s);
   endtask

   task automatic measure_ready(input int start, output int n);
      n = start;
      while (ready !== 1'b1 && n < 100) begin
         step(1);
         n++;
      end
   endtask

   task automatic rand_div();
      for (int i = 0; i < NCH; i++) div[i*DW +: DW] = 8'($urandom_range(0, 7));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      resetb     = 1'b0;
      locked_raw = 1'b0;
      div        = {8'd0, 8'd3, 8'd2, 8'd1};
      step(3);
      chk("rst_state", state, 0);
      chk("rst_ce", ce, 0);
      chk("rst_ready", ready, 0);
      chk("rst_rst_out_n", rst_out_n, 0);
      chk("rst_lost", lost_cnt, 0);

      // Lock-up: locked_raw high from cycle 0.
      resetb     = 1'b1;
      locked_raw = 1'b1;
      chk_on     = 1'b1;
      repeat (18) @(posedge clk);
      @(negedge clk);
      chk("lockup_settle_c18", state, 1);
      @(negedge clk);
      chk("lockup_run_c19", state, 2);
      chk("lockup_ready_c19", ready, 0);
      chk("lockup_ce_run1", ce, 4'b1001);
      @(negedge clk);
      chk("lockup_ready_c20", ready, 1);
      chk("lockup_ce_run2", ce, 4'b1011);
      @(negedge clk);
      chk("lockup_ce_run3", ce, 4'b1101);

      // Glitch filter: 3-cycle drop ignored, 6-cycle drop faults.
      step(5);
      locked_raw = 1'b0;
      step(3);
      locked_raw = 1'b1;
      step(10);
      chk("glitch_state", state, 2);
      chk("glitch_lost", lost_cnt, 0);
      locked_raw = 1'b0;
      step(6);
      chk("fault_state", state, 3);
      locked_raw = 1'b1;
      step(1);
      chk("fault_exit_state", state, 0);
      chk("fault_lost", lost_cnt, 1);
      chk("fault_ready", ready, 0);
      measure_ready(1, n);
      chk("relock_latency", n, 20);

      // SETTLE abort: drop at SETTLE cycle 10, full recount afterwards.
      locked_raw = 1'b0;
      step(8);
      locked_raw = 1'b1;
      wait_state(2'd1, 10, "abort_enter_settle");
      step(9);
      locked_raw = 1'b0;
      step(3);
      chk("abort_state", state, 0);
      locked_raw = 1'b1;
      measure_ready(0, n);
      chk("abort_relock_latency", n, 20);
      chk("abort_lost", lost_cnt, 2);

      // Divisor change 200 -> 100 at cnt=150.
      div[7:0] = 8'd200;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ce[0] !== 1'b1 && n < 300);
      chk("div_first_ce", ce[0], 1);
      repeat (151) @(posedge clk);
      #2;
      div[7:0] = 8'd100;
      @(negedge clk);
      chk("div_change_ce", ce[0], 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ce[0] !== 1'b1 && n < 300);
      chk("div_new_period", n, 100);

      // Random lock behaviour and divisors.
      step(1);
      for (int seg = 0; seg < 40; seg++) begin
         locked_raw = 1'b1;
         step($urandom_range(0, 60));
         if ($urandom_range(0, 3) == 0) rand_div();
         locked_raw = 1'b0;
         step($urandom_range(1, 8));
      end

      // Saturation: 260 further lock-loss events.
      for (int k = 0; k < 260; k++) begin
         locked_raw = 1'b1;
         wait_state(2'd2, 60, "sat_run");
         step($urandom_range(0, 5));
         if ($urandom_range(0, 1) == 1) begin
            locked_raw = 1'b0;
            step($urandom_range(1, 3));
            locked_raw = 1'b1;
            step(2);
         end
         if ($urandom_range(0, 7) == 0) rand_div();
         locked_raw = 1'b0;
         step($urandom_range(6, 9));
      end
      locked_raw = 1'b1;
      wait_state(2'd2, 60, "sat_final_run");
      chk("sat_lost", lost_cnt, 255);

      // Asynchronous reset mid-RUN, checked between clock edges.
      div = {8'd1, 8'd1, 8'd1, 8'd1};
      step(5);
      @(posedge clk);
      #3;
      resetb = 1'b0;
      #1;
      chk("areset_ce", ce, 0);
      chk("areset_rst_out_n", rst_out_n, 0);
      chk("areset_lost", lost_cnt, 0);
      chk("areset_state", state, 0);
      chk("areset_ready", ready, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pll_clk_mgr.md
# pll_clk_mgr

Parametrised clock manager that sits directly behind the iCE40 PLL's global output. It qualifies the PLL lock signal (synchronised, settle-timed, glitch-filtered) and releases a synchronous downstream reset once the clock is stable. It generates NCH independently programmable clock-enable strobes, replacing the one-output-frequency-per-PLL-instance approach. It also counts lock-loss events for diagnostics.

## Interface
Parameters:
- NCH, 4: number of clock-enable channels (1..16).
- DIV_W, 8: width of each channel divisor.
- LOCK_WAIT, 1024: cycles `lock_s` must stay high before RUN (≥2).
- GLITCH_FILT, 4: consecutive low cycles of `lock_s` in RUN that count as lock loss (≥1).

Ports:
- clock_in  in  1  PLL global output clock; only clock of the block.
- resetb  in  1  asynchronous, active-low reset.
- locked_raw  in  1  PLL LOCK, asynchronous to clock_in.
- div  in  NCH*DIV_W  per-channel divisor; channel i uses bits [i*DIV_W +: DIV_W]; 0 is treated as 1.
- ce  out  NCH  per-channel one-cycle enable strobe.
- rst_out_n  out  1  synchronous active-low reset for downstream logic.
- ready  out  1  high while in RUN.
- lost_cnt  out  8  saturating count of lock-loss events.
- state  out  2  FSM state: 0 WAIT_LOCK, 1 SETTLE, 2 RUN, 3 FAULT.

## Operation
- `locked_raw` passes through a 2-flop synchroniser; its output is `lock_s`. Both flops reset to 0.
- FSM (registered, reset to WAIT_LOCK):
  - WAIT_LOCK: settle_cnt=0. If lock_s=1, go to SETTLE.
  - SETTLE: if lock_s=0, go to WAIT_LOCK. Otherwise settle_cnt increments. When settle_cnt==LOCK_WAIT-1 with lock_s=1, go to RUN. SETTLE therefore lasts exactly LOCK_WAIT cycles.
  - RUN: low_cnt increments while lock_s=0 and clears to 0 when lock_s=1. If lock_s=0 and low_cnt==GLITCH_FILT-1, go to FAULT.
  - FAULT: lasts exactly one cycle. lost_cnt increments, saturating at 255. Next state is WAIT_LOCK.
- ready and rst_out_n are registered. Each is 1 exactly in the cycle after the state register holds RUN, so both track `state==RUN` delayed by one cycle.
- Dividers, per channel i:
  - div_eff = (div_i==0) ? 1 : div_i.
  - cnt_i is a DIV_W-bit counter. It is held at 0 outside RUN.
  - In RUN: if cnt_i ≥ div_eff-1, then cnt_i←0 and ce[i]=1; otherwise cnt_i increments and ce[i]=0.
  - ce[i] is a combinational decode of registered state and cnt_i, gated by state==RUN. It is 0 in every other state.
- Changing div mid-period:
  - Takes effect immediately.
  - If the new div_eff-1 ≤ the current cnt_i, ce fires in the next cycle and the counter wraps.
  - The counter never runs past the divisor.
- All channels share the RUN entry cycle, so equal divisors are phase-aligned.

## Timing
- Reset values: state=0, ce=0, rst_out_n=0, ready=0, lost_cnt=0. All internal counters are 0.
- Latency from locked_raw rising (stable) to RUN: 2 synchroniser cycles + 1 (WAIT_LOCK→SETTLE) + LOCK_WAIT. ready/rst_out_n rise 1 cycle later.
- First ce[i] after entering RUN comes in RUN cycle div_eff, with cycles numbered from 1. With div_eff=1, ce is high every RUN cycle.
- Lock loss in RUN: FAULT is entered on the GLITCH_FILT-th consecutive low lock_s cycle. ce drops the same cycle state leaves RUN. ready/rst_out_n drop 1 cycle later.
- A low pulse on lock_s of up to GLITCH_FILT-1 cycles in RUN is ignored entirely: no state change and no ce disturbance.
- A lock_s drop during SETTLE restarts qualification with no lost_cnt increment.
- Assertion of resetb (async) forces all reset values immediately, including mid-RUN. Deassertion restarts from WAIT_LOCK.

## Test plan
- Lock-up, with LOCK_WAIT=16, div={1,2,3,0}: resetb released, locked_raw=1 at cycle 0. Required: state=RUN at cycle 19 and ready=1 at cycle 20. ce[0] and ce[3] pulse every cycle, ce[1] every 2nd cycle, ce[2] every 3rd cycle; first ce[2] in the 3rd RUN cycle.
- Glitch filter, with GLITCH_FILT=4: in RUN, drop locked_raw for 3 cycles. Required: state stays RUN and lost_cnt=0. Then drop it for 6 cycles. Required: FAULT for one cycle, lost_cnt=1, ready=0, then WAIT_LOCK; relock gives ready again after the 19+1 cycles.
- SETTLE abort: drop locked_raw at SETTLE cycle 10. Required: return to WAIT_LOCK, lost_cnt unchanged, and a full LOCK_WAIT re-count before RUN.
- Divisor change: with div=200 (DIV_W=8), at cnt=150 set div=100. Required: ce in the next cycle, then a period of 100.
- Saturation and async reset:
  - Force 260 lock-loss events. Required: lost_cnt=255.
  - Assert resetb mid-RUN asynchronously. Required: ce=0, rst_out_n=0, lost_cnt=0 without waiting for a clock edge.
